// File: rtl/lsu_param.sv
// Per-thread load/store unit: base+offset addressing, one valid/ready memory
// transaction per LDR/STR. Optional watchdog timeout enabled by LSU_TIMEOUT_EN.
module lsu_param #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int STATE_BITS = 4,
    parameter logic [STATE_BITS-1:0] REQUEST_STATE = 4'b0100,
    parameter logic [STATE_BITS-1:0] UPDATE_STATE = 4'b0111,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [STATE_BITS-1:0] core_state,
    input  logic                  decoded_mem_read_enable,
    input  logic                  decoded_mem_write_enable,
    input  logic [ADDR_BITS-1:0]  rs,
    input  logic [ADDR_BITS-1:0]  addr_offset,
    input  logic [DATA_BITS-1:0]  rt,
    output logic                  mem_read_valid,
    output logic [ADDR_BITS-1:0]  mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [DATA_BITS-1:0]  mem_read_data,
    output logic                  mem_write_valid,
    output logic [ADDR_BITS-1:0]  mem_write_address,
    output logic [DATA_BITS-1:0]  mem_write_data,
    input  logic                  mem_write_ready,
    output logic [1:0]            lsu_state,
    output logic [DATA_BITS-1:0]  lsu_out,
    output logic                  lsu_error
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t                state_q;
    logic                  op_read_q;
    logic                  rd_valid_q;
    logic                  wr_valid_q;
    logic [ADDR_BITS-1:0]  rd_addr_q;
    logic [ADDR_BITS-1:0]  wr_addr_q;
    logic [DATA_BITS-1:0]  wr_data_q;
    logic [DATA_BITS-1:0]  out_q;
    logic [ADDR_BITS-1:0]  addr_d;
    logic                  ready_d;

    // Carry out of the add is deliberately dropped so addresses wrap.
    assign addr_d  = rs + addr_offset;
    assign ready_d = op_read_q ? mem_read_ready : mem_write_ready;

`ifdef LSU_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);
    logic [WD_BITS-1:0] wd_q;
    logic               error_q;
    assign lsu_error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = |32'(TIMEOUT_CYCLES);
    assign lsu_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_read_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_q      <= '0;
`ifdef LSU_TIMEOUT_EN
            wd_q       <= '0;
            error_q    <= 1'b0;
`endif
        end else if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (core_state == REQUEST_STATE &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        op_read_q <= decoded_mem_read_enable;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (op_read_q) begin
                        rd_valid_q <= 1'b1;
                        rd_addr_q  <= addr_d;
                    end else begin
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= addr_d;
                        wr_data_q  <= rt;
                    end
`ifdef LSU_TIMEOUT_EN
                    wd_q    <= '0;
                    error_q <= 1'b0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A ready on the final watchdog cycle still completes cleanly.
                    if (ready_d) begin
                        rd_valid_q <= 1'b0;
                        wr_valid_q <= 1'b0;
                        if (op_read_q) out_q <= mem_read_data;
                        state_q <= S_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        rd_valid_q <= 1'b0;
                        wr_valid_q <= 1'b0;
                        if (op_read_q) out_q <= '1;
                        error_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (core_state == UPDATE_STATE) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = out_q;

endmodule

// File: tb/tb_lsu_param.sv
// Directed bench for lsu_param: load, store, wrap, reset abort, enable stall,
// and watchdog (or no-timeout) behaviour depending on LSU_TIMEOUT_EN.
module tb_lsu_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] core_state;
    logic       rd_en, wr_en;
    logic [7:0] rs, addr_offset, rt;
    logic       mem_read_valid, mem_read_ready;
    logic [7:0] mem_read_address, mem_read_data;
    logic       mem_write_valid, mem_write_ready;
    logic [7:0] mem_write_address, mem_write_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_param #(
        .ADDR_BITS(8), .DATA_BITS(8), .STATE_BITS(4),
        .REQUEST_STATE(4'b0100), .UPDATE_STATE(4'b0111),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .rs(rs), .addr_offset(addr_offset), .rt(rt),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a request from IDLE and advance into WAITING.
    task automatic start_op(input logic r, input logic w, input logic [7:0] base,
                            input logic [7:0] off, input logic [7:0] data);
        core_state = 4'b0100; rd_en = r; wr_en = w;
        rs = base; addr_offset = off; rt = data;
        step();
        check("req_state", 32'(lsu_state), 32'd1);
        core_state = 4'b0000; rd_en = 1'b0; wr_en = 1'b0;
        step();
        check("wait_state", 32'(lsu_state), 32'd2);
    endtask

    task automatic retire();
        core_state = 4'b0111;
        step();
        check("retire_idle", 32'(lsu_state), 32'd0);
        core_state = 4'b0000;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = 4'b0000;
        rd_en = 1'b0; wr_en = 1'b0; rs = '0; addr_offset = '0; rt = '0;
        mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_state", 32'(lsu_state), 32'd0);
        check("rst_rvalid", 32'(mem_read_valid), 32'd0);
        check("rst_wvalid", 32'(mem_write_valid), 32'd0);
        check("rst_out", 32'(lsu_out), 32'd0);
        check("rst_err", 32'(lsu_error), 32'd0);
        step();
        check("idle_hold", 32'(lsu_state), 32'd0);

        // Load: 0x10+0x05, ready one extra cycle later
        start_op(1'b1, 1'b0, 8'h10, 8'h05, 8'h00);
        check("ld_rvalid", 32'(mem_read_valid), 32'd1);
        check("ld_addr", 32'(mem_read_address), 32'h15);
        check("ld_wvalid", 32'(mem_write_valid), 32'd0);
        step();
        check("ld_still_wait", 32'(lsu_state), 32'd2);
        mem_read_ready = 1'b1; mem_read_data = 8'hA5;
        step();
        mem_read_ready = 1'b0; mem_read_data = 8'h00;
        check("ld_done", 32'(lsu_state), 32'd3);
        check("ld_rvalid_drop", 32'(mem_read_valid), 32'd0);
        check("ld_out", 32'(lsu_out), 32'hA5);
        step();
        check("ld_done_hold", 32'(lsu_state), 32'd3);
        retire();

        // Store with ready already high: valid lasts exactly one cycle
        start_op(1'b0, 1'b1, 8'h20, 8'h00, 8'h3C);
        check("st_wvalid", 32'(mem_write_valid), 32'd1);
        check("st_addr", 32'(mem_write_address), 32'h20);
        check("st_data", 32'(mem_write_data), 32'h3C);
        check("st_rvalid", 32'(mem_read_valid), 32'd0);
        mem_write_ready = 1'b1;
        step();
        mem_write_ready = 1'b0;
        check("st_done", 32'(lsu_state), 32'd3);
        check("st_wvalid_drop", 32'(mem_write_valid), 32'd0);
        check("st_out_kept", 32'(lsu_out), 32'hA5);
        retire();

        // Wrap-around address, both enables high -> read wins
        start_op(1'b1, 1'b1, 8'hFE, 8'h03, 8'h99);
        check("wr_addr", 32'(mem_read_address), 32'h01);
        check("both_rvalid", 32'(mem_read_valid), 32'd1);
        check("both_wvalid", 32'(mem_write_valid), 32'd0);
        mem_write_ready = 1'b1;
        step();
        mem_write_ready = 1'b0;
        check("other_ready_ignored", 32'(lsu_state), 32'd2);
        mem_read_ready = 1'b1; mem_read_data = 8'h5A;
        step();
        mem_read_ready = 1'b0;
        check("both_out", 32'(lsu_out), 32'h5A);
        check("both_wvalid_never", 32'(mem_write_valid), 32'd0);
        retire();

        // enable low for 4 cycles with ready high: frozen
        start_op(1'b1, 1'b0, 8'h30, 8'h01, 8'h00);
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h77;
        for (int i = 0; i < 4; i++) begin
            step();
            check("en_low_state", 32'(lsu_state), 32'd2);
            check("en_low_rvalid", 32'(mem_read_valid), 32'd1);
            check("en_low_out", 32'(lsu_out), 32'h5A);
        end
        enable = 1'b1;
        step();
        mem_read_ready = 1'b0;
        check("en_resume_done", 32'(lsu_state), 32'd3);
        check("en_resume_out", 32'(lsu_out), 32'h77);
        retire();

        // Reset in WAITING aborts
        start_op(1'b1, 1'b0, 8'h44, 8'h00, 8'h00);
        check("pre_rst_rvalid", 32'(mem_read_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_state", 32'(lsu_state), 32'd0);
        check("abort_rvalid", 32'(mem_read_valid), 32'd0);
        check("abort_out", 32'(lsu_out), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // No ready: 4th WAITING cycle times out
        start_op(1'b1, 1'b0, 8'h40, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_wait", 32'(lsu_state), 32'd2);
        end
        step();
        check("to_done", 32'(lsu_state), 32'd3);
        check("to_err", 32'(lsu_error), 32'd1);
        check("to_out", 32'(lsu_out), 32'hFF);
        check("to_rvalid", 32'(mem_read_valid), 32'd0);
        retire();
        start_op(1'b0, 1'b1, 8'h50, 8'h00, 8'h11);
        check("to_err_cleared", 32'(lsu_error), 32'd0);
        mem_write_ready = 1'b1;
        step();
        mem_write_ready = 1'b0;
        retire();
        // Ready exactly on the limit cycle completes without error
        start_op(1'b1, 1'b0, 8'h60, 8'h00, 8'h00);
        step(); step(); step();
        mem_read_ready = 1'b1; mem_read_data = 8'h3E;
        step();
        mem_read_ready = 1'b0;
        check("limit_done", 32'(lsu_state), 32'd3);
        check("limit_err", 32'(lsu_error), 32'd0);
        check("limit_out", 32'(lsu_out), 32'h3E);
`else
        start_op(1'b1, 1'b0, 8'h40, 8'h00, 8'h00);
        for (int i = 0; i < 1000; i++) step();
        check("noto_state", 32'(lsu_state), 32'd2);
        check("noto_rvalid", 32'(mem_read_valid), 32'd1);
        check("noto_err", 32'(lsu_error), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
